// File: rtl/load_extend_sequencer_if.sv
// load_extend_sequencer_if: control/memory/result bus of the load sequencer
interface load_extend_sequencer_if;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  dataSize;
    logic        signedLd;
    logic        busy;
    logic        memRead;
    logic [31:0] memAddr;
    logic        MFC;
    logic [31:0] memData;
    logic [31:0] Out;
    logic        done;
    logic        fault;
    modport slave (
        input  start, addr, dataSize, signedLd, MFC, memData,
        output busy, memRead, memAddr, Out, done, fault
    );
    modport master (
        output start, addr, dataSize, signedLd, MFC, memData,
        input  busy, memRead, memAddr, Out, done, fault
    );
endinterface

// File: rtl/load_extend_sequencer.sv
// load_extend_sequencer: one memory load per request with lane select and sign/zero extension (optional MISALIGN_TRAP_EN)
module load_extend_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic Clk,
    input logic CLR,
    load_extend_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, EXT, DONE} state_t;
    state_t         r_state, w_next;
    logic [31:0]    r_addr, r_data, r_out;
    logic [1:0]     r_size;
    logic           r_signed, r_fault;
    logic [TW-1:0]  r_timer;
    logic           w_mis, w_timeout;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_ext;
`ifdef MISALIGN_TRAP_EN
    assign w_mis = (bus.dataSize == 2'b01 && bus.addr[0]) || (bus.dataSize[1] && bus.addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    assign w_timeout = !bus.MFC && r_timer == TW'(TIMEOUT_CYCLES - 1);
    assign w_byte = r_data[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_data[{r_addr[1], 4'b0000} +: 16];
    assign w_ext = r_size == 2'b00 ? {{24{r_signed & w_byte[7]}}, w_byte} :
                   r_size == 2'b01 ? {{16{r_signed & w_half[15]}}, w_half} : r_data;
    assign bus.busy    = r_state != IDLE;
    assign bus.memRead = r_state == REQ;
    assign bus.done    = r_state == DONE;
    assign bus.fault   = r_fault & bus.done;
    assign bus.memAddr = r_addr;
    assign bus.Out     = r_out;
    // next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? (w_mis ? DONE : REQ) : IDLE;
            REQ:     w_next = bus.MFC ? EXT : (w_timeout ? DONE : REQ);
            EXT:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    // state register plus request latch, MFC capture, timeout timer and result
    always_ff @(posedge Clk) begin
        if (CLR) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_out    <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_fault  <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_addr   <= bus.addr;
                r_size   <= bus.dataSize;
                r_signed <= bus.signedLd;
                r_timer  <= '0;
                r_fault  <= w_mis;
                if (w_mis) r_out <= '0;
            end
            if (r_state == REQ) begin
                if (bus.MFC) begin
                    r_data  <= bus.memData;
                    r_timer <= '0;
                end else if (w_timeout) begin
                    r_timer <= '0;
                    r_fault <= 1'b1;
                    r_out   <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
            if (r_state == EXT) begin
                r_out   <= w_ext;
                r_fault <= 1'b0;
            end
        end
    end
endmodule
